mult_booth: RTL and testbench

MULT_BOOTH -- requirements
Module: mult_booth

---
 rtl/mult_pkg.sv | 14 +
 rtl/booth_step.sv | 43 ++++
 rtl/mult_booth.sv | 159 +++++++++++++++
 tb/tb_mult_booth.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   MultWidth    : default operand width
//   mult_state_e : controller state encoding (idle / run / done)
package mult_pkg;

    localparam int unsigned MultWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } mult_state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract/skip the multiplicand into the upper
// accumulator according to the multiplier LSB pair, then shift {acc, q, q_m1} right
// arithmetically by one.
// Ports:
//   acc       : upper accumulator, one bit wider than the operands
//   q         : multiplier / low product bits
//   q_m1      : bit shifted out of q on the previous step
//   mcand     : signed multiplicand
//   acc_next  : accumulator after the step
//   q_next    : multiplier register after the step
//   q_m1_next : new shifted-out bit
module booth_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] mcand_ext;
    logic [WIDTH:0] sum;

    // The extra accumulator bit keeps -(most-negative) representable.
    assign mcand_ext = {mcand[WIDTH-1], mcand};

    always_comb begin
        sum = acc;
        unique case ({q[0], q_m1})
            2'b01:   sum = acc + mcand_ext;
            2'b10:   sum = acc - mcand_ext;
            default: sum = acc;
        endcase
    end

    assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next    = {sum[0], q[WIDTH-1:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/mult_booth.sv
// Sequential signed multiplier using radix-2 Booth recoding, one step per clock.
// A start in idle/done latches a and b; WIDTH steps follow, then the full
// 2*WIDTH-bit product is loaded into hi/lo and done pulses for one cycle.
// Optional feature: define MULT_ZERO_SKIP_EN to complete zero-operand requests
// one edge after the start edge without entering the run state.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   start : request a multiply of the current a/b (ignored while busy)
//   a     : multiplicand (signed)
//   b     : multiplier (signed)
//   hi    : upper half of the product, held until the next completion
//   lo    : lower half of the product, held until the next completion
//   busy  : high while in the run state
//   done  : high for the cycle in which hi/lo become valid
module mult_booth
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    mult_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic             q_m1_q, q_m1_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] q_step;
    logic             q_m1_step;

`ifdef MULT_ZERO_SKIP_EN
    // Zero operand seen on the start edge; completion follows on the next edge.
    logic skip_q, skip_d;
`endif

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc       (acc_q),
        .q         (q_q),
        .q_m1      (q_m1_q),
        .mcand     (mcand_q),
        .acc_next  (acc_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        q_d     = q_q;
        acc_d   = acc_q;
        q_m1_d  = q_m1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULT_ZERO_SKIP_EN
        skip_d  = 1'b0;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
`ifdef MULT_ZERO_SKIP_EN
                if (skip_q) begin
                    state_d = StDone;
                    hi_d    = '0;
                    lo_d    = '0;
                end else
`endif
                if (start) begin
                    mcand_d = a;
                    q_d     = b;
                    acc_d   = '0;
                    q_m1_d  = 1'b0;
                    cnt_d   = CntW'(WIDTH);
                    state_d = StRun;
`ifdef MULT_ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                        skip_d  = 1'b1;
                    end
`endif
                end
            end

            StRun: begin
                if (cnt_q != '0) begin
                    acc_d  = acc_step;
                    q_d    = q_step;
                    q_m1_d = q_m1_step;
                    cnt_d  = cnt_q - CntW'(1);
                end else begin
                    // Product fits in 2*WIDTH bits, so the accumulator's top bit is redundant.
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = q_q;
                    state_d = StDone;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mcand_q <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            q_m1_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            q_m1_q  <= q_m1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

`ifdef MULT_ZERO_SKIP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end
`endif

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth: stimulus pushes the expected product and completion
// cycle; a monitor pops and compares on every done pulse.
module tb_mult_booth;

    localparam int unsigned W = 32;

`ifdef MULT_ZERO_SKIP_EN
    localparam int   ZeroLat  = 1;
    localparam logic ZeroBusy = 1'b0;
`else
    localparam int   ZeroLat  = 33;
    localparam logic ZeroBusy = 1'b1;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mult_booth #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("hi", 64'(hi), 64'(mon_e.hi));
                check("lo", 64'(lo), 64'(mon_e.lo));
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo,
                            input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        a     = ta;
        b     = tb_;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        reset = 1'b0;

        // 3 * 4 = 12
        do_start(32'd3, 32'd4, 32'h0, 32'hC, 33, 1'b1);
        check("busy_run_3x4", 64'(busy), 64'(1));
        wait_drain("t_3x4");
        check("busy_after_3x4", 64'(busy), 64'(0));
        @(negedge clk);
        check("done_cleared_3x4", 64'(done), 64'(0));
        check("lo_hold_3x4", 64'(lo), 64'hC);

        // -1 * 1 = -1
        do_start(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1);
        wait_drain("t_neg1x1");

        // most-negative squared = 2^62
        do_start(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, 1'b1);
        wait_drain("t_minxmin");

        // 5 * 7 with start re-pulsed and operands changed mid-run
        do_start(32'd5, 32'd7, 32'h0, 32'd35, 33, 1'b1);
        repeat (5) @(negedge clk);
        a     = 32'd100;
        b     = 32'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 32'd1;
        b     = 32'hFFFF_FFFF;
        check("busy_repulse", 64'(busy), 64'(1));
        check("hi_hold_run", 64'(hi), 64'h4000_0000);
        wait_drain("t_5x7");

        // Reset ten cycles into a run: cleared outputs, no completion
        do_start(32'd9, 32'd11, 32'h0, 32'h0, 0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        // 2 * -3 = -6
        do_start(32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33, 1'b1);
        wait_drain("t_2xm3");

        // 0 * 9: early completion only when zero-skip is built in
        do_start(32'd0, 32'd9, 32'h0, 32'h0, ZeroLat, 1'b1);
        check("busy_zero", 64'(busy), 64'(ZeroBusy));
        wait_drain("t_0x9");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
